// File: rtl/rx_pkg.sv
// Sizing helpers shared by the serial receive FIFO and its storage block.
// Build option: define RX_PARITY_EN to append one parity bit to every frame.
package rx_pkg;

    function automatic int frame_len(input int data_w);
`ifdef RX_PARITY_EN
        return data_w + 1;
`else
        return data_w;
`endif
    endfunction

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Bit counter must hold FRAME_LEN+1 so an over-long frame stays distinguishable.
    function automatic int bitcnt_w(input int data_w);
        return $clog2(frame_len(data_w) + 2);
    endfunction

endpackage

// File: rtl/sync_fifo_ptr.sv
// Show-ahead synchronous FIFO: storage, wrapping pointers, occupancy count and flags.
// A push into a full FIFO is accepted only when a pop retires the head in the same cycle.
module sync_fifo_ptr
    import rx_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    push_i,
    input  logic                    pop_i,
    input  logic [WIDTH-1:0]        wdata_i,
    output logic [WIDTH-1:0]        rdata_o,
    output logic                    empty_o,
    output logic                    full_o,
    output logic [cnt_w(DEPTH)-1:0] count_o
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, last_ptr;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok, pop_ok;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    // While empty, keep presenting the slot that was read last.
    assign last_ptr = rd_ptr_q - PW'(1);
    assign rdata_o  = empty_o ? mem_q[last_ptr] : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/rx_shift_fifo.sv
// Serial frame receiver: shifts strobed bits in, commits whole frames into a FIFO.
// Build option: define RX_PARITY_EN for a trailing parity bit and per-entry perr.
module rx_shift_fifo
    import rx_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int DEPTH      = 4,
    parameter int MSB_FIRST  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                    clk,
    input  logic                    Rst,
    input  logic                    shift_strobe,
    input  logic                    packet_done,
    input  logic                    rx,
    input  logic                    rd_en,
    input  logic                    clr_ovr,
    output logic [DATA_W-1:0]       rdata,
    output logic                    perr,
    output logic                    empty,
    output logic                    full,
    output logic [cnt_w(DEPTH)-1:0] count,
    output logic                    frame_err,
    output logic                    overrun
);

    localparam int FRAME_LEN = frame_len(DATA_W);
    localparam int BW        = bitcnt_w(DATA_W);
    localparam logic [BW-1:0] CNT_SAT  = BW'(FRAME_LEN + 1);
    localparam logic [BW-1:0] CNT_GOOD = BW'(FRAME_LEN);
`ifdef RX_PARITY_EN
    localparam int ENTRY_W = DATA_W + 1;
`else
    localparam int ENTRY_W = DATA_W;
`endif

    if (DATA_W < 5 || DATA_W > 16 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 ||
        MSB_FIRST < 0 || MSB_FIRST > 1 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_cfg
        $error("rx_shift_fifo: unsupported parameter set");
    end

    logic [FRAME_LEN-1:0] sr_q, sr_d;
    logic [BW-1:0]        bitcnt_q, bitcnt_d, eff_cnt;
    logic                 frame_err_q, frame_err_d, overrun_q, overrun_d;
    logic                 good, push, drop;
    logic [DATA_W-1:0]    frame_data;
    logic [ENTRY_W-1:0]   wdata, rentry;

    // The strobe of this cycle is folded in before the commit decision.
    always_comb begin
        sr_d    = sr_q;
        eff_cnt = bitcnt_q;
        if (shift_strobe) begin
            if (MSB_FIRST != 0) sr_d = {sr_q[FRAME_LEN-2:0], rx};
            else                sr_d = {rx, sr_q[FRAME_LEN-1:1]};
            if (bitcnt_q != CNT_SAT) eff_cnt = bitcnt_q + BW'(1);
        end
        bitcnt_d = packet_done ? '0 : eff_cnt;
    end

    assign frame_data  = (MSB_FIRST != 0) ? sr_d[FRAME_LEN-1 -: DATA_W] : sr_d[DATA_W-1:0];
    assign good        = packet_done && (eff_cnt == CNT_GOOD);
    assign drop        = good && full && !rd_en;
    assign push        = good && !drop;
    assign frame_err_d = packet_done && (eff_cnt != CNT_GOOD);
    assign overrun_d   = drop ? 1'b1 : (clr_ovr ? 1'b0 : overrun_q);

`ifdef RX_PARITY_EN
    logic par_bit;
    assign par_bit = (MSB_FIRST != 0) ? sr_d[0] : sr_d[FRAME_LEN-1];
    assign wdata   = {(((^frame_data) ^ par_bit) != (PARITY_ODD != 0)), frame_data};
    assign perr    = rentry[DATA_W];
`else
    assign wdata   = frame_data;
    assign perr    = 1'b0;
`endif
    assign rdata     = rentry[DATA_W-1:0];
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            sr_q        <= '0;
            bitcnt_q    <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            sr_q        <= sr_d;
            bitcnt_q    <= bitcnt_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    sync_fifo_ptr #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (Rst),
        .push_i  (push),
        .pop_i   (rd_en),
        .wdata_i (wdata),
        .rdata_o (rentry),
        .empty_o (empty),
        .full_o  (full),
        .count_o (count)
    );

endmodule

// File: tb/tb_rx_shift_fifo.sv
// Bench for rx_shift_fifo: LSB-first and MSB-first instances driven by the same serial stream.
// Build option: define RX_PARITY_EN to exercise the parity variant.
module tb_rx_shift_fifo;

    localparam int DW  = 8;
    localparam int DEP = 4;
`ifdef RX_PARITY_EN
    localparam int FL = DW + 1;
`else
    localparam int FL = DW;
`endif

    logic          clk = 1'b0;
    logic          Rst, shift_strobe, packet_done, rx, rd_en, clr_ovr;
    logic [DW-1:0] rdata_l, rdata_m;
    logic          perr_l, perr_m, empty_l, empty_m, full_l, full_m;
    logic          ferr_l, ferr_m, ovr_l, ovr_m;
    logic [2:0]    count_l, count_m;

    int checks = 0;
    int errors = 0;
    int mdl_cnt = 0;
    bit mdl_ovr = 1'b0;
    logic [DW-1:0] exp_lsb_q[$];
    logic [DW-1:0] exp_msb_q[$];
    logic          exp_perr_q[$];

    always #5 clk = ~clk;

    rx_shift_fifo #(.DATA_W(DW), .DEPTH(DEP), .MSB_FIRST(0), .PARITY_ODD(0)) u_lsb (
        .clk(clk), .Rst(Rst), .shift_strobe(shift_strobe), .packet_done(packet_done),
        .rx(rx), .rd_en(rd_en), .clr_ovr(clr_ovr), .rdata(rdata_l), .perr(perr_l),
        .empty(empty_l), .full(full_l), .count(count_l), .frame_err(ferr_l), .overrun(ovr_l)
    );

    rx_shift_fifo #(.DATA_W(DW), .DEPTH(DEP), .MSB_FIRST(1), .PARITY_ODD(0)) u_msb (
        .clk(clk), .Rst(Rst), .shift_strobe(shift_strobe), .packet_done(packet_done),
        .rx(rx), .rd_en(rd_en), .clr_ovr(clr_ovr), .rdata(rdata_m), .perr(perr_m),
        .empty(empty_m), .full(full_m), .count(count_m), .frame_err(ferr_m), .overrun(ovr_m)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model;
        exp_lsb_q.delete();
        exp_msb_q.delete();
        exp_perr_q.delete();
        mdl_cnt = 0;
        mdl_ovr = 1'b0;
    endtask

    // Sends n strobed bits (data LSB first, then parity) and a packet_done.
    task automatic send_frame(input logic [DW-1:0] d, input int n, input bit par_bad,
                              input bit same_cycle, input bit pop, input bit clr);
        logic [15:0]   bits;
        logic [DW-1:0] dm;
        logic [4:0]    exp_st;
        bit            good, popped, drop, exp_pe;
        bits     = 16'(d);
        bits[DW] = (^d) ^ par_bad;
        for (int i = 0; i < DW; i++) dm[DW-1-i] = d[i];
`ifdef RX_PARITY_EN
        exp_pe = par_bad;
`else
        exp_pe = 1'b0;
`endif
        for (int i = 0; i < n - (same_cycle ? 1 : 0); i++) begin
            shift_strobe = 1'b1;
            rx = bits[i];
            tick;
        end
        shift_strobe = same_cycle;
        rx           = same_cycle ? bits[n-1] : 1'b0;
        packet_done  = 1'b1;
        rd_en        = pop;
        clr_ovr      = clr;
        popped       = pop && (mdl_cnt > 0);
        if (popped) begin
            checks++;
            if (rdata_l !== exp_lsb_q[0] || rdata_m !== exp_msb_q[0] || perr_l !== exp_perr_q[0]) begin
                errors++;
                $display("FAIL frame_pop_head: got lsb=%h msb=%h perr=%b expected lsb=%h msb=%h perr=%b",
                         rdata_l, rdata_m, perr_l, exp_lsb_q[0], exp_msb_q[0], exp_perr_q[0]);
            end
            void'(exp_lsb_q.pop_front());
            void'(exp_msb_q.pop_front());
            void'(exp_perr_q.pop_front());
        end
        tick;
        shift_strobe = 1'b0;
        packet_done  = 1'b0;
        rd_en        = 1'b0;
        clr_ovr      = 1'b0;
        good = (n == FL);
        if (popped) mdl_cnt--;
        drop = good && (mdl_cnt == DEP);
        if (good && !drop) begin
            exp_lsb_q.push_back(d);
            exp_msb_q.push_back(dm);
            exp_perr_q.push_back(exp_pe);
            mdl_cnt++;
        end
        if (drop) mdl_ovr = 1'b1;
        else if (clr) mdl_ovr = 1'b0;
        exp_st = {3'(mdl_cnt), mdl_cnt == 0, mdl_cnt == DEP};
        checks++;
        if ({count_l, empty_l, full_l} !== exp_st || {count_m, empty_m, full_m} !== exp_st) begin
            errors++;
            $display("FAIL frame_status: got lsb=%b msb=%b expected %b (cnt,empty,full)",
                     {count_l, empty_l, full_l}, {count_m, empty_m, full_m}, exp_st);
        end
        checks++;
        if (ferr_l !== !good || ferr_m !== !good || ovr_l !== mdl_ovr || ovr_m !== mdl_ovr) begin
            errors++;
            $display("FAIL frame_flags: got ferr=%b/%b ovr=%b/%b expected ferr=%b ovr=%b",
                     ferr_l, ferr_m, ovr_l, ovr_m, !good, mdl_ovr);
        end
    endtask

    task automatic pop_one;
        bit popped;
        logic [4:0] exp_st;
        rd_en  = 1'b1;
        popped = (mdl_cnt > 0);
        if (popped) begin
            checks++;
            if (rdata_l !== exp_lsb_q[0] || rdata_m !== exp_msb_q[0] ||
                perr_l !== exp_perr_q[0] || perr_m !== exp_perr_q[0]) begin
                errors++;
                $display("FAIL pop_data: got lsb=%h msb=%h perr=%b expected lsb=%h msb=%h perr=%b",
                         rdata_l, rdata_m, perr_l, exp_lsb_q[0], exp_msb_q[0], exp_perr_q[0]);
            end
            void'(exp_lsb_q.pop_front());
            void'(exp_msb_q.pop_front());
            void'(exp_perr_q.pop_front());
        end
        tick;
        rd_en = 1'b0;
        if (popped) mdl_cnt--;
        exp_st = {3'(mdl_cnt), mdl_cnt == 0, mdl_cnt == DEP};
        checks++;
        if ({count_l, empty_l, full_l} !== exp_st || {count_m, empty_m, full_m} !== exp_st) begin
            errors++;
            $display("FAIL pop_status: got lsb=%b msb=%b expected %b", {count_l, empty_l, full_l},
                     {count_m, empty_m, full_m}, exp_st);
        end
    endtask

    task automatic test_reset;
        Rst = 1'b1; shift_strobe = 1'b0; packet_done = 1'b0; rx = 1'b0; rd_en = 1'b0; clr_ovr = 1'b0;
        tick;
        tick;
        Rst = 1'b0;
        tick;
        clear_model();
        checks++;
        if ({count_l, empty_l, full_l, ferr_l, ovr_l, perr_l} !== 8'b000_1_0_0_0_0 ||
            {count_m, empty_m, full_m, ferr_m, ovr_m, perr_m} !== 8'b000_1_0_0_0_0) begin
            errors++;
            $display("FAIL reset_status: got lsb=%b msb=%b expected 00010000",
                     {count_l, empty_l, full_l, ferr_l, ovr_l, perr_l}, {count_m, empty_m, full_m, ferr_m, ovr_m, perr_m});
        end
        checks++;
        if (rdata_l !== 8'h00 || rdata_m !== 8'h00) begin
            errors++;
            $display("FAIL reset_rdata: got %h/%h expected 00", rdata_l, rdata_m);
        end
    endtask

    task automatic test_basic;
        send_frame(8'hC5, FL, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (rdata_l !== 8'hC5 || rdata_m !== 8'hA3 || count_l !== 3'd1 || empty_l !== 1'b0) begin
            errors++;
            $display("FAIL basic_c5: got lsb=%h msb=%h count=%0d empty=%b expected C5 A3 1 0",
                     rdata_l, rdata_m, count_l, empty_l);
        end
        pop_one();
    endtask

    task automatic test_same_cycle;
        send_frame(8'h5A, FL, 1'b0, 1'b1, 1'b0, 1'b0);
        send_frame(8'h81, FL, 1'b0, 1'b1, 1'b0, 1'b0);
        pop_one();
        pop_one();
        pop_one();
    endtask

    task automatic test_frame_err;
        send_frame(8'h3E, FL, 1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(8'h77, 7, 1'b0, 1'b0, 1'b0, 1'b0);
        tick;
        checks++;
        if (ferr_l !== 1'b0 || ferr_m !== 1'b0 || count_l !== 3'd1) begin
            errors++;
            $display("FAIL frame_err_pulse: got ferr=%b/%b count=%0d expected 0/0 1", ferr_l, ferr_m, count_l);
        end
        send_frame(8'h12, FL + 1, 1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(8'h34, FL + 3, 1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(8'hE9, FL, 1'b0, 1'b0, 1'b0, 1'b0);
        pop_one();
        pop_one();
    endtask

    task automatic test_overrun;
        for (int i = 0; i < 5; i++) begin
            send_frame(8'($urandom), FL, 1'b0, 1'b0, 1'b0, 1'b0);
            if (i == 3) begin
                checks++;
                if (full_l !== 1'b1 || ovr_l !== 1'b0) begin
                    errors++;
                    $display("FAIL ovr_full4: got full=%b ovr=%b expected 1 0", full_l, ovr_l);
                end
            end
        end
        for (int i = 0; i < 3; i++) tick;
        checks++;
        if (ovr_l !== 1'b1 || ovr_m !== 1'b1 || count_l !== 3'd4) begin
            errors++;
            $display("FAIL ovr_sticky: got ovr=%b/%b count=%0d expected 1 1 4", ovr_l, ovr_m, count_l);
        end
        send_frame(8'hAA, FL, 1'b0, 1'b0, 1'b0, 1'b1);
        clr_ovr = 1'b1;
        tick;
        clr_ovr = 1'b0;
        mdl_ovr = 1'b0;
        checks++;
        if (ovr_l !== 1'b0 || ovr_m !== 1'b0) begin
            errors++;
            $display("FAIL ovr_clear: got %b/%b expected 0", ovr_l, ovr_m);
        end
    endtask

    task automatic test_full_push_pop;
        send_frame(8'h3C, FL, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (count_l !== 3'd4 || full_l !== 1'b1 || ovr_l !== 1'b0) begin
            errors++;
            $display("FAIL full_push_pop: got count=%0d full=%b ovr=%b expected 4 1 0", count_l, full_l, ovr_l);
        end
        for (int i = 0; i < DEP + 1; i++) pop_one();
    endtask

`ifdef RX_PARITY_EN
    task automatic test_parity;
        send_frame(8'h07, FL, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (perr_l !== 1'b1 || perr_m !== 1'b1 || count_l !== 3'd1) begin
            errors++;
            $display("FAIL parity_bad: got perr=%b/%b count=%0d expected 1 1 1", perr_l, perr_m, count_l);
        end
        pop_one();
        send_frame(8'h07, FL, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (perr_l !== 1'b0 || perr_m !== 1'b0) begin
            errors++;
            $display("FAIL parity_good: got perr=%b/%b expected 0", perr_l, perr_m);
        end
        pop_one();
    endtask
`endif

    task automatic test_reset_midframe;
        send_frame(8'h66, FL, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            shift_strobe = 1'b1;
            rx = 1'($urandom_range(0, 1));
            tick;
        end
        shift_strobe = 1'b0;
        Rst = 1'b1;
        #2;
        checks++;
        if (empty_l !== 1'b1 || count_l !== 3'd0 || count_m !== 3'd0) begin
            errors++;
            $display("FAIL async_reset: got empty=%b count=%0d/%0d expected 1 0", empty_l, count_l, count_m);
        end
        tick;
        Rst = 1'b0;
        clear_model();
        tick;
        send_frame(8'h9D, FL, 1'b0, 1'b0, 1'b0, 1'b0);
        pop_one();
    endtask

    task automatic test_random;
        for (int it = 0; it < 30; it++) begin
            if ($urandom_range(0, 3) == 0) pop_one();
            else send_frame(8'($urandom), ($urandom_range(0, 7) == 0) ? FL - 1 : FL,
                            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                            1'($urandom_range(0, 1)), $urandom_range(0, 5) == 0);
        end
        for (int i = 0; i < DEP + 1; i++) pop_one();
        clr_ovr = 1'b1;
        tick;
        clr_ovr = 1'b0;
        mdl_ovr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_same_cycle();
        test_frame_err();
        test_overrun();
        test_full_push_pop();
`ifdef RX_PARITY_EN
        test_parity();
`endif
        test_reset_midframe();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rx_shift_fifo.md
RX_SHIFT_FIFO -- requirements
Module: rx_shift_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 8: data bits per frame, 5..16.
REQ-002 SHALL have parameter DEPTH, default 4: FIFO entries, power of 2, at least 2.
REQ-003 SHALL have parameter MSB_FIRST, default 0: 0 = first received bit becomes data LSB; 1 = first received bit becomes data MSB.
REQ-004 SHALL have parameter PARITY_ODD, default 0: 1 = odd parity, 0 = even parity; used only under RX_PARITY_EN.
REQ-005 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-006 SHALL have port Rst, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port shift_strobe, input, 1: sample rx into the shift register this cycle.
REQ-008 SHALL have port packet_done, input, 1: frame boundary; commit the frame this cycle.
REQ-009 SHALL have port rx, input, 1: serial data bit.
REQ-010 SHALL have port rd_en, input, 1: pop the head entry.
REQ-011 SHALL have port clr_ovr, input, 1: clear the sticky overrun flag.
REQ-012 SHALL have port rdata, output, DATA_W: head entry data (show-ahead).
REQ-013 SHALL have port perr, output, 1: head entry parity error.
REQ-014 SHALL have ports empty and full, outputs, 1 each: FIFO status.
REQ-015 SHALL have port count, output, $clog2(DEPTH)+1: number of occupied entries.
REQ-016 SHALL have port frame_err, output, 1: one-cycle pulse when a frame has the wrong bit count.
REQ-017 SHALL have port overrun, output, 1: sticky flag, set when a good frame is dropped because the FIFO is full.

Function
REQ-018 FRAME_LEN SHALL equal DATA_W, or DATA_W+1 under RX_PARITY_EN; the shift register SHALL be FRAME_LEN bits wide.
REQ-019 On shift_strobe with MSB_FIRST=0, the register SHALL shift right with rx entering the MSB; with MSB_FIRST=1 it SHALL shift left with rx entering bit 0.
REQ-020 A bit counter SHALL increment on each shift_strobe, saturate at FRAME_LEN+1, and clear on packet_done.
REQ-021 When shift_strobe and packet_done occur in the same cycle, that cycle's bit SHALL be included in the committed frame (shift first, then commit).
REQ-022 At packet_done with effective count == FRAME_LEN, the frame is good: it SHALL be pushed if a slot is free, otherwise dropped with overrun set.
REQ-023 At packet_done with effective count != FRAME_LEN, frame_err SHALL pulse for 1 cycle and nothing SHALL be pushed.
REQ-024 Data extraction with MSB_FIRST=0 SHALL be sr[DATA_W-1:0]; with MSB_FIRST=1 it SHALL be sr[FRAME_LEN-1 -: DATA_W].
REQ-025 A pushed entry SHALL appear on rdata/empty/count the cycle after the packet_done edge (latency 1).
REQ-026 rd_en while empty SHALL be ignored with no pointer change; rd_en while not empty SHALL advance the head at the next edge.
REQ-027 A simultaneous push and pop while full SHALL succeed, leaving count unchanged; while empty, the pop SHALL be ignored and the push SHALL succeed.
REQ-028 Pointers SHALL wrap modulo DEPTH; full SHALL equal (count == DEPTH) and empty SHALL equal (count == 0).
REQ-029 overrun SHALL stay set until clr_ovr; clr_ovr in the same cycle as a new drop SHALL leave overrun set.
REQ-030 When empty, rdata and perr SHALL hold the last-read slot contents; they are don't-care to consumers.

Reset
REQ-031 Rst SHALL asynchronously clear the shift register, bit counter, pointers, count, overrun, frame_err and all FIFO storage to 0, giving empty=1 and full=0.
REQ-032 Rst asserted mid-frame SHALL discard the partial frame; the first packet_done after release SHALL count only post-reset strobes.

Configuration
REQ-033 With RX_PARITY_EN defined: the last strobed bit SHALL be parity; perr = (XOR of data and parity) != PARITY_ODD, stored per entry; a parity-bad frame SHALL still be pushed.
REQ-034 Without RX_PARITY_EN: FRAME_LEN SHALL equal DATA_W, perr SHALL be tied to 0, and no per-entry parity storage SHALL exist.

Structure
REQ-035 Package rx_pkg SHALL hold the FRAME_LEN computation function and the count/pointer width localparam helpers.
REQ-036 Storage SHALL be a sub-module sync_fifo_ptr (pointer, count and flag logic); shift/commit logic SHALL stay in rx_shift_fifo.

Verification
REQ-037 Bench SHALL cover default params: strobe bits 1,0,1,0,0,0,1,1 then packet_done -> next cycle rdata=8'hC5, count=1, empty=0.
REQ-038 Bench SHALL cover MSB_FIRST=1 with the same bits -> rdata=8'hA3.
REQ-039 Bench SHALL cover 5 good frames with no reads at DEPTH=4 -> full=1 after the 4th, 5th dropped, overrun=1 until clr_ovr.
REQ-040 Bench SHALL cover 7 strobes then packet_done -> frame_err pulses 1 cycle, count unchanged.
REQ-041 Bench SHALL cover full FIFO with packet_done and rd_en in the same cycle -> count stays 4, new frame at the tail, overrun=0.
REQ-042 Bench SHALL cover RX_PARITY_EN with even parity, data 8'h07 and parity bit 0 -> entry pushed with perr=1; parity bit 1 -> perr=0.
